// File: rtl/reg_demux_pkg.sv
// rtl/reg_demux_pkg.sv - shared FSM states, register-bus structs and sizing helper
package reg_demux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FWD    = 2'd1,
        DECERR = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int unsigned REG_AW = 32;
    localparam int unsigned REG_DW = 32;

    typedef struct packed {
        logic [REG_AW-1:0]   addr;
        logic                write;
        logic [REG_DW-1:0]   wdata;
        logic [REG_DW/8-1:0] wstrb;
        logic                valid;
    } reg_req_t;

    typedef struct packed {
        logic [REG_DW-1:0] rdata;
        logic              error;
        logic              ready;
    } reg_rsp_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_demux_if.sv
// rtl/reg_demux_if.sv - register-bus request/response bundle with master/slave views
interface reg_demux_if #(
    parameter type req_t = reg_demux_pkg::reg_req_t,
    parameter type rsp_t = reg_demux_pkg::reg_rsp_t
) ();

    req_t req;
    rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);

endinterface

// File: rtl/reg_addr_decode.sv
// rtl/reg_addr_decode.sv - base/mask address match with lowest-index priority
module reg_addr_decode #(
    parameter int unsigned   NoPorts = 32'd2,
    parameter int unsigned   AW      = 32,
    parameter int unsigned   IW      = 1,
    parameter logic [AW-1:0] AddrBase [NoPorts] = '{default: '0},
    parameter logic [AW-1:0] AddrMask [NoPorts] = '{default: '0}
) (
    input  logic [AW-1:0] i_addr,
    output logic          o_hit,
    output logic [IW-1:0] o_idx
);

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = int'(NoPorts) - 1; i >= 0; i--) begin
            if ((i_addr & AddrMask[i]) == AddrBase[i]) begin
                o_hit = 1'b1;
                o_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/reg_demux.sv
// rtl/reg_demux.sv - one-outstanding register-bus demultiplexer with decode error and timeout
module reg_demux
    import reg_demux_pkg::*;
#(
    parameter int unsigned   NoPorts       = 32'd2,
    parameter int unsigned   AW            = 32,
    parameter int unsigned   DW            = 32,
    parameter type           req_t         = reg_req_t,
    parameter type           rsp_t         = reg_rsp_t,
    parameter logic [AW-1:0] AddrBase [NoPorts] = '{default: '0},
    parameter logic [AW-1:0] AddrMask [NoPorts] = '{default: '0},
    parameter int unsigned   TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  req_t in_req_i,
    output rsp_t in_rsp_o,
    output req_t out_req_o [NoPorts],
    input  rsp_t out_rsp_i [NoPorts]
);

    localparam int unsigned   IW      = idx_width(NoPorts);
    localparam int unsigned   CW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CW-1:0] CntLast = (TimeoutCycles > 0) ? CW'(TimeoutCycles - 1) : '0;
    localparam logic [CW-1:0] CntMax  = {CW{1'b1}};

    state_e r_state;
    state_e w_state_nxt;

    logic [AW-1:0]   r_addr;
    logic            r_write;
    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_wstrb;
    logic [IW-1:0]   r_sel;
    logic [DW-1:0]   r_rdata;
    logic            r_error;
    logic [CW-1:0]   r_cnt;

    logic            w_hit;
    logic [IW-1:0]   w_idx;
    logic            w_sel_ready;
    logic [DW-1:0]   w_sel_rdata;
    logic            w_sel_error;
    logic            w_timeout;

    reg_addr_decode #(
        .NoPorts  (NoPorts),
        .AW       (AW),
        .IW       (IW),
        .AddrBase (AddrBase),
        .AddrMask (AddrMask)
    ) u_decode (
        .i_addr (in_req_i.addr),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        w_sel_error = 1'b0;
        for (int i = 0; i < int'(NoPorts); i++) begin
            if (r_sel == IW'(i)) begin
                w_sel_ready = out_rsp_i[i].ready;
                w_sel_rdata = out_rsp_i[i].rdata;
                w_sel_error = out_rsp_i[i].error;
            end
        end
    end

    // r_cnt holds the number of FWD cycles already spent, so the last allowed cycle sees TimeoutCycles-1.
    assign w_timeout = (TimeoutCycles != 0) && (r_cnt == CntLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_req_i.valid) w_state_nxt = w_hit ? FWD : DECERR;
            FWD:     if (w_sel_ready || w_timeout) w_state_nxt = RESP;
            DECERR:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_req_i.valid) begin
                        r_addr  <= in_req_i.addr;
                        r_write <= in_req_i.write;
                        r_wdata <= in_req_i.wdata;
                        r_wstrb <= in_req_i.wstrb;
                        r_sel   <= w_idx;
                        r_cnt   <= '0;
                    end
                end
                FWD: begin
                    if (w_sel_ready) begin
                        r_rdata <= w_sel_rdata;
                        r_error <= w_sel_error;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_error <= 1'b1;
                    end else if (r_cnt != CntMax) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DECERR: begin
                    r_rdata <= '0;
                    r_error <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Every port sees the captured payload; only the selected one gets valid.
    always_comb begin
        in_rsp_o = '0;
        if (r_state == RESP) begin
            in_rsp_o.ready = 1'b1;
            in_rsp_o.rdata = r_rdata;
            in_rsp_o.error = r_error;
        end
        for (int i = 0; i < int'(NoPorts); i++) begin
            out_req_o[i]       = '0;
            out_req_o[i].addr  = r_addr;
            out_req_o[i].write = r_write;
            out_req_o[i].wdata = r_wdata;
            out_req_o[i].wstrb = r_wstrb;
            out_req_o[i].valid = (r_state == FWD) && (r_sel == IW'(i));
        end
    end

endmodule
